// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: width-op indices,
// FSM encoding and access-size helpers.
package mem_lsu_pkg;

  localparam int XLEN      = 64;
  localparam int BUS_BYTES = 8;

  // Bit positions inside the one-hot width op {B,H,W,D,BU,HU,WU}
  localparam int WDT_B  = 6;
  localparam int WDT_H  = 5;
  localparam int WDT_W  = 4;
  localparam int WDT_D  = 3;
  localparam int WDT_BU = 2;
  localparam int WDT_HU = 1;
  localparam int WDT_WU = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DONE     = 2'd3
  } lsuState_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } accSize_t;

  localparam logic [7:0] MASK_B = 8'h01;
  localparam logic [7:0] MASK_H = 8'h03;
  localparam logic [7:0] MASK_W = 8'h0F;
  localparam logic [7:0] MASK_D = 8'hFF;

  // Anything that is not exactly one-hot falls back to a doubleword access.
  function automatic accSize_t wdtSize(input logic [6:0] wdtOp);
    case (wdtOp)
      7'(1 << WDT_B), 7'(1 << WDT_BU): wdtSize = SZ_B;
      7'(1 << WDT_H), 7'(1 << WDT_HU): wdtSize = SZ_H;
      7'(1 << WDT_W), 7'(1 << WDT_WU): wdtSize = SZ_W;
      default:                         wdtSize = SZ_D;
    endcase
  endfunction

  function automatic logic [7:0] sizeMask(input accSize_t sz);
    case (sz)
      SZ_B:    sizeMask = MASK_B;
      SZ_H:    sizeMask = MASK_H;
      SZ_W:    sizeMask = MASK_W;
      default: sizeMask = MASK_D;
    endcase
  endfunction

  function automatic logic isAligned(input accSize_t sz, input logic [2:0] off);
    case (sz)
      SZ_B:    isAligned = 1'b1;
      SZ_H:    isAligned = ~off[0];
      SZ_W:    isAligned = (off[1:0] == 2'b00);
      default: isAligned = (off == 3'b000);
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-memory bus: one valid/ready request channel and a valid-only
// load response channel.
interface mem_lsu_if #(
  parameter int XLEN      = mem_lsu_pkg::XLEN,
  parameter int BUS_BYTES = mem_lsu_pkg::BUS_BYTES
);

  logic                   reqValid;
  logic                   reqReady;
  logic [XLEN-1:0]        reqAddr;
  logic                   reqWen;
  logic [BUS_BYTES-1:0]   reqWmask;
  logic [BUS_BYTES*8-1:0] reqWdata;
  logic                   rspValid;
  logic [BUS_BYTES*8-1:0] rspRdata;

  modport master (
    output reqValid, reqAddr, reqWen, reqWmask, reqWdata,
    input  reqReady, rspValid, rspRdata
  );

  modport slave (
    input  reqValid, reqAddr, reqWen, reqWmask, reqWdata,
    output reqReady, rspValid, rspRdata
  );

endinterface

// File: rtl/mem_lsu_load_ext.sv
// Load data alignment: shift the addressed lane down to bit 0 and
// sign/zero-extend according to the width op.
module mem_load_ext
  import mem_lsu_pkg::*;
#(
  parameter int XLEN = mem_lsu_pkg::XLEN
) (
  input  logic [BUS_BYTES*8-1:0] rdata,
  input  logic [2:0]             laneOff,
  input  logic [6:0]             wdtOp,
  output logic [XLEN-1:0]        extData
);

  logic [BUS_BYTES*8-1:0] shifted;

  assign shifted = rdata >> {laneOff, 3'b000};

  always_comb begin
    extData = XLEN'(shifted);
    case (wdtOp)
      7'(1 << WDT_B):  extData = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      7'(1 << WDT_H):  extData = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      7'(1 << WDT_W):  extData = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      7'(1 << WDT_BU): extData = {{(XLEN-8){1'b0}},         shifted[7:0]};
      7'(1 << WDT_HU): extData = {{(XLEN-16){1'b0}},        shifted[15:0]};
      7'(1 << WDT_WU): extData = {{(XLEN-32){1'b0}},        shifted[31:0]};
      default:         extData = XLEN'(shifted);
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues one bus transaction per memory op,
// stalls the pipeline until it completes and returns the WB value.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int XLEN      = mem_lsu_pkg::XLEN,
  parameter int BUS_BYTES = mem_lsu_pkg::BUS_BYTES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_MEM,
  input  logic             ld_MEM,
  input  logic             st_MEM,
  input  logic [6:0]       wdt_op_MEM,
  input  logic [XLEN-1:0]  alu_result_MEM,
  input  logic [XLEN-1:0]  store_data_MEM,
  input  logic [4:0]       rd_MEM,
  mem_lsu_if.master        dmem,
  output logic             stall_MEM,
  output logic [XLEN-1:0]  mem_result_MEM,
  output logic [4:0]       rd_out_MEM,
  output logic             misalign_MEM
);

  localparam int BUS_W = BUS_BYTES * 8;

  lsuState_t            state, stateNext;
  accSize_t             reqSize;
  logic [2:0]           laneOff;
  logic                 active, aligned, issue;
  logic                 stallRaw, misalignRaw;

  logic [XLEN-1:0]      busAddr;
  logic                 busWen;
  logic [BUS_BYTES-1:0] busMask;
  logic [BUS_W-1:0]     busData;
  logic [2:0]           latOff;
  logic [6:0]           latOp;
  logic [XLEN-1:0]      extData;
  logic [XLEN-1:0]      loadData;

  assign laneOff = alu_result_MEM[2:0];
  assign reqSize = wdtSize(wdt_op_MEM);
  assign active  = (ld_MEM | st_MEM) & ~flush_MEM;
  assign aligned = isAligned(reqSize, laneOff);
  assign issue   = (state == ST_IDLE) & active & aligned;

  mem_load_ext #(.XLEN(XLEN)) uLoadExt (
    .rdata   (dmem.rspRdata),
    .laneOff (latOff),
    .wdtOp   (latOp),
    .extData (extData)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      loadData <= '0;
    end else begin
      state <= stateNext;
      if (state == ST_WAIT_RSP && dmem.rspValid)
        loadData <= extData;
    end
  end

  // Request fields are captured once at issue and held for the whole transaction
  always_ff @(posedge clk) begin
    if (issue) begin
      busAddr <= {alu_result_MEM[XLEN-1:3], 3'b000};
      busWen  <= st_MEM;
      busMask <= sizeMask(reqSize) << laneOff;
      busData <= BUS_W'(store_data_MEM << {laneOff, 3'b000});
      latOff  <= laneOff;
      latOp   <= wdt_op_MEM;
    end
  end

  always_comb begin
    stateNext      = state;
    stallRaw       = 1'b0;
    misalignRaw    = 1'b0;
    mem_result_MEM = alu_result_MEM;
    case (state)
      ST_IDLE: begin
        if (active) begin
          if (aligned) begin
            stateNext = ST_REQ;
            stallRaw  = 1'b1;
          end else begin
            misalignRaw = 1'b1;
          end
        end
      end
      ST_REQ: begin
        stallRaw = 1'b1;
        if (dmem.reqReady)
          stateNext = busWen ? ST_DONE : ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        stallRaw = 1'b1;
        if (dmem.rspValid)
          stateNext = ST_DONE;
      end
      ST_DONE: begin
        stateNext = ST_IDLE;
        if (!busWen)
          mem_result_MEM = loadData;
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  assign stall_MEM     = stallRaw & ~rst;
  assign misalign_MEM  = misalignRaw & ~rst;
  assign rd_out_MEM    = rd_MEM;

  assign dmem.reqValid = (state == ST_REQ);
  assign dmem.reqAddr  = busAddr;
  assign dmem.reqWen   = busWen;
  assign dmem.reqWmask = busMask;
  assign dmem.reqWdata = busData;

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- MEM-stage load/store unit, directly downstream of the EX/MEM pipeline register.
- Consumes the EX/MEM outputs: ALU result as the effective address, width op, load/store flags, store data and bubble flag.
- Issues one valid/ready transaction on the data-memory bus, aligns and sign/zero-extends load data, and stalls the pipeline until the access completes.
- Non-memory instructions pass the ALU result through with zero added latency.

Parameters:
XLEN, 64, datapath/address width
BUS_BYTES, 8, data bus width in bytes (fixed 8; addr[2:0] is the byte lane)

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
flush_MEM  input  1  bubble marker from EX/MEM; 1 = no architectural op
ld_MEM  input  1  instruction is a load
st_MEM  input  1  instruction is a store
wdt_op_MEM  input  7  one-hot width type {B,H,W,D,BU,HU,WU}
alu_result_MEM  input  XLEN  effective address / non-memory result
store_data_MEM  input  XLEN  rs2 value for stores
rd_MEM  input  5  destination register index (passed through)
dmem_req_valid  output  1  request valid
dmem_req_ready  input  1  request accepted
dmem_req_addr  output  XLEN  address with [2:0] cleared
dmem_req_wen  output  1  1 = store
dmem_req_wmask  output  8  byte enables
dmem_req_wdata  output  64  lane-shifted store data
dmem_rsp_valid  input  1  load response valid
dmem_rsp_rdata  input  64  load response data
stall_MEM  output  1  freeze IF..EX/MEM registers
mem_result_MEM  output  XLEN  value for WB
rd_out_MEM  output  5  rd_MEM passthrough
misalign_MEM  output  1  misaligned access, one-cycle pulse

Behaviour:
- State machine: IDLE, REQ, WAIT_RSP, DONE. Reset (async) forces IDLE, dmem_req_valid=0, captured load data=0.
- While rst is high, stall_MEM=0 and misalign_MEM=0.
- Definition: active = (ld_MEM|st_MEM) & ~flush_MEM.
- Alignment rule: H/HU need addr[0]=0; W/WU need addr[1:0]=0; D needs addr[2:0]=0.

IDLE:
- Active and aligned: go to REQ; stall_MEM=1 combinationally in this same cycle.
- Active and misaligned: misalign_MEM=1 for that cycle; no request issued; stall_MEM=0; stay in IDLE.
- Not active: stall_MEM=0; mem_result_MEM=alu_result_MEM.

REQ:
- dmem_req_valid=1, with addr/wen/wmask/wdata registered and held stable until dmem_req_ready=1.
- Handshake completes on the cycle with valid&ready.
- On handshake: a store goes to DONE; a load goes to WAIT_RSP.
- stall_MEM=1.

WAIT_RSP:
- Waits for dmem_rsp_valid. On response, latch extended data and go to DONE.
- A response arriving in the same cycle as the request handshake is not allowed by the bus; the bench must not drive it.
- stall_MEM=1.

DONE:
- Lasts exactly 1 cycle; stall_MEM=0.
- mem_result_MEM = latched load data for a load, alu_result_MEM for a store.
- Then returns to IDLE, where the next EX/MEM contents are evaluated (no re-issue of the same op).

Store encoding:
- wmask = {1,3,F,FF}[size] << addr[2:0].
- wdata = store_data << (8*addr[2:0]); upper bytes discarded.

Load extraction:
- Shift: r = rsp_rdata >> (8*addr[2:0]).
- B/H/W sign-extend bit 7/15/31; BU/HU/WU zero-extend; D takes all 64 bits.

Latency:
- Store: 2 stall cycles minimum (IDLE, REQ), plus one extra per cycle of ready=0.
- Load: minimum 3 stall cycles (IDLE, REQ, WAIT_RSP).

Boundary conditions:
- flush_MEM is only sampled in IDLE. Inputs are frozen by stall_MEM during a transaction, so a mid-operation change is illegal.
- An issued request is never withdrawn.
- Async reset mid-transaction drops valid immediately. The memory side is reset by the same rst.
- wdt_op_MEM not one-hot on an active op: treated as D.

Decomposition:
- Shared defines: XLEN, one-hot indices of wdt_op (WDT_B..WDT_WU), FSM state encoding (2 bits), size-to-mask constants.
- One sub-module: mem_load_ext, purely combinational (rdata, addr[2:0], wdt_op -> extended XLEN value).
- FSM and bus registers stay in mem_lsu.

Test Plan:
- Non-memory op, alu_result=0x1234 -> stall_MEM=0, mem_result_MEM=0x1234 same cycle, dmem_req_valid never asserted.
- Store SB, addr=0x80000003, data=0xAB, ready=1 immediately -> req_addr=0x80000000, wmask=0x08, wdata[31:24]=0xAB, stall for 2 cycles, DONE with stall=0.
- Load LB, addr=0x80000005, rdata=0x0000_8000_0000_0000, ready delayed 3 cycles, rsp 2 cycles later -> mem_result_MEM=0xFFFF_FFFF_FFFF_FF80 in DONE; with LBU -> 0x80.
- LW at addr=0x...2 -> misalign_MEM pulses 1 cycle, no request, stall_MEM=0.
- flush_MEM=1 with ld_MEM=1 -> no request, stall_MEM=0.
- Assert rst while in REQ with ready=0 -> next edge dmem_req_valid=0, state IDLE, stall_MEM=0.
